systolic_skew_feeder: RTL and testbench

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

---
 rtl/systolic_skew_feeder.sv | 135 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Streams k_steps A/B operand beats into an NxN systolic array with per-lane skew; done at k_steps+3N cycles after start.
// Backpressure: in_ready is high only while feeding, and a cycle without in_valid freezes the skew lines and holds en low.
module systolic_skew_feeder #(
   parameter int N         = 4,
   parameter int DATA_W    = 16,
   parameter int DRAIN_CYC = 3*N-2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [15:0]         k_steps,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N*DATA_W-1:0] in_a,
   input  logic [N*DATA_W-1:0] in_b,
   output logic [N*DATA_W-1:0] a_left,
   output logic [N*DATA_W-1:0] b_top,
   output logic                clear_acc,
   output logic                en,
   output logic                busy,
   output logic                done
);

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

   localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYC - 1);

   state_t              state;
   logic [15:0]         k_lat;
   logic [15:0]         beat_cnt;
   logic [15:0]         drain_cnt;
   logic                advance;
   logic                line_clr;
   logic                last_beat;
   logic                last_drain;
   logic [N*DATA_W-1:0] feed_a;
   logic [N*DATA_W-1:0] feed_b;

   assign in_ready   = (state == FEED);
   assign advance    = (in_ready && in_valid) || (state == DRAIN);
   assign line_clr   = reset || (state == CLEAR);
   assign feed_a     = in_ready ? in_a : '0;
   assign feed_b     = in_ready ? in_b : '0;
   // Counter stops one short of k_lat, so k_steps=65535 never wraps it.
   assign last_beat  = (beat_cnt == k_lat - 16'd1);
   assign last_drain = (drain_cnt == DRAIN_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         k_lat     <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         clear_acc <= 1'b0;
         en        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         en <= advance;
         case (state)
            IDLE: begin
               if (start) begin
                  k_lat     <= k_steps;
                  beat_cnt  <= '0;
                  clear_acc <= 1'b1;
                  busy      <= 1'b1;
                  state     <= CLEAR;
               end
            end
            CLEAR: begin
               clear_acc <= 1'b0;
               if (k_lat != 16'd0) begin
                  state <= FEED;
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            FEED: begin
               if (advance) begin
                  beat_cnt <= beat_cnt + 16'd1;
                  if (last_beat) begin
                     drain_cnt <= '0;
                     state     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 16'd1;
               if (last_drain) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               clear_acc <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   // Lane i carries i+1 stages so it trails lane 0 by i advances.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DATA_W-1:0] a_sr [i+1];
      logic [DATA_W-1:0] b_sr [i+1];

      always_ff @(posedge clk) begin
         if (line_clr) begin
            for (int j = 0; j <= i; j++) begin
               a_sr[j] <= '0;
               b_sr[j] <= '0;
            end
         end else if (advance) begin
            a_sr[0] <= feed_a[i*DATA_W +: DATA_W];
            b_sr[0] <= feed_b[i*DATA_W +: DATA_W];
            for (int j = 1; j <= i; j++) begin
               a_sr[j] <= a_sr[j-1];
               b_sr[j] <= b_sr[j-1];
            end
         end
      end

      assign a_left[i*DATA_W +: DATA_W] = a_sr[i];
      assign b_top[i*DATA_W +: DATA_W]  = b_sr[i];
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: per-tile expected timeline built from the valid pattern, plus an output-stationary PE array checked against A*B.
module tb_systolic_skew_feeder;

   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int DRAIN = 3*N-2;
   localparam int BW    = N*DW;
   localparam int MAXC  = 128;

   logic          clk;
   logic          reset;
   logic          start;
   logic [15:0]   k_steps;
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in_a;
   logic [BW-1:0] in_b;
   logic [BW-1:0] a_left;
   logic [BW-1:0] b_top;
   logic          clear_acc;
   logic          en;
   logic          busy;
   logic          done;

   int checks   = 0;
   int failures = 0;

   systolic_skew_feeder #(.N(N), .DATA_W(DW), .DRAIN_CYC(DRAIN)) dut (
      .clk(clk), .reset(reset), .start(start), .k_steps(k_steps),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .a_left(a_left), .b_top(b_top), .clear_acc(clear_acc), .en(en),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic signed [DW-1:0] lane(input logic [BW-1:0] v, input int i);
      return v[i*DW +: DW];
   endfunction

   // Output-stationary PE grid fed by the DUT: A flows right, B flows down.
   longint                acc [N][N];
   logic signed [DW-1:0]  pa  [N][N];
   logic signed [DW-1:0]  pb  [N][N];

   function automatic logic signed [DW-1:0] a_in(input int r, input int c);
      return (c == 0) ? lane(a_left, r) : pa[r][(c > 0) ? c-1 : 0];
   endfunction

   function automatic logic signed [DW-1:0] b_in(input int r, input int c);
      return (r == 0) ? lane(b_top, c) : pb[(r > 0) ? r-1 : 0][c];
   endfunction

   always @(posedge clk) begin
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (clear_acc) begin
               acc[r][c] <= 0;
               pa[r][c]  <= '0;
               pb[r][c]  <= '0;
            end else if (en) begin
               acc[r][c] <= acc[r][c] + longint'(a_in(r, c)) * longint'(b_in(r, c));
               pa[r][c]  <= a_in(r, c);
               pb[r][c]  <= b_in(r, c);
            end
         end
      end
   end

   // mode: 0 valid held, 1 random stalls, 2 valid low on cycles 4 and 5.
   // data: 0 random, 1 A lanes {1,2,3,4}, 2 lanes biased to -32768/32767.
   task automatic run_tile(input int k, input int mode, input int data, input int restart_c, input int reset_c);
      logic          vld [MAXC];
      logic [BW-1:0] da  [MAXC];
      logic [BW-1:0] db  [MAXC];
      int            bc  [$];
      int            last, done_c, stop, n_adv, rs;
      logic          e_en, e_beat;
      logic [BW-1:0] ea, eb;
      longint        ref_c;

      for (int c = 0; c < MAXC; c++) begin
         case (mode)
            0:       vld[c] = 1'b1;
            1:       vld[c] = (c >= 60) || ($urandom_range(0, 99) >= 30);
            default: vld[c] = !(c == 4 || c == 5);
         endcase
         for (int i = 0; i < N; i++) begin
            da[c][i*DW +: DW] = DW'($urandom);
            db[c][i*DW +: DW] = DW'($urandom);
            if (data == 1) da[c][i*DW +: DW] = DW'(i + 1);
            if (data == 2) begin
               if ((c + i) % 3 == 0) da[c][i*DW +: DW] = 16'h8000;
               if ((c + i) % 3 == 1) da[c][i*DW +: DW] = 16'h7fff;
               if ((c + i) % 3 == 1) db[c][i*DW +: DW] = 16'h8000;
               if ((c + i) % 3 == 2) db[c][i*DW +: DW] = 16'h7fff;
            end
         end
      end

      for (int c = 2; c < MAXC && bc.size() < k; c++)
         if (vld[c]) bc.push_back(c);
      last   = (k > 0) ? bc[k-1] : 1;
      done_c = (k > 0) ? last + 1 + DRAIN : 2;
      stop   = (reset_c > 0) ? reset_c + 1 : done_c + 1;
      rs     = (restart_c < done_c + 1) ? restart_c : 0;
      n_adv  = 0;

      for (int c = 0; c <= stop; c++) begin
         @(posedge clk);
         #1;
         reset    = (reset_c > 0) && (c == reset_c);
         start    = (c == 0) || (rs > 0 && c == rs);
         k_steps  = (c == 0) ? 16'(k) : 16'($urandom);
         in_valid = vld[c];
         in_a     = da[c];
         in_b     = db[c];
         @(negedge clk);
         if (reset_c > 0 && c == stop) begin
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            chk("rst_clear",    64'(clear_acc), 64'(0));
            chk("rst_en",       64'(en), 64'(0));
            chk("rst_busy",     64'(busy), 64'(0));
            chk("rst_done",     64'(done), 64'(0));
            chk("rst_a_left",   64'(a_left), 64'(0));
            chk("rst_b_top",    64'(b_top), 64'(0));
         end else begin
            e_beat = (k > 0) && (c - 1 >= 2) && (c - 1 <= last) && vld[c-1];
            e_en   = e_beat || ((k > 0) && (c - 1 > last) && (c - 1 <= last + DRAIN));
            if (e_en) n_adv++;
            for (int i = 0; i < N; i++) begin
               int idx;
               idx = n_adv - 1 - i;
               ea[i*DW +: DW] = (idx >= 0 && idx < k) ? da[bc[idx]][i*DW +: DW] : '0;
               eb[i*DW +: DW] = (idx >= 0 && idx < k) ? db[bc[idx]][i*DW +: DW] : '0;
            end
            chk("in_ready",  64'(in_ready),  64'((k > 0) && c >= 2 && c <= last));
            chk("clear_acc", 64'(clear_acc), 64'(c == 1));
            chk("busy",      64'(busy),      64'(c >= 1 && c <= done_c));
            chk("done",      64'(done),      64'(c == done_c));
            chk("en",        64'(en),        64'(e_en));
            chk("a_left",    64'(a_left),    64'(ea));
            chk("b_top",     64'(b_top),     64'(eb));
         end
      end

      if (reset_c == 0) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               ref_c = 0;
               for (int j = 0; j < k; j++)
                  ref_c += longint'(lane(da[bc[j]], r)) * longint'(lane(db[bc[j]], c));
               chk("c_out", 64'(acc[r][c]), 64'(ref_c));
            end
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      k_steps  = '0;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 64'(in_ready), 64'(0));
      chk("reset_clear",    64'(clear_acc), 64'(0));
      chk("reset_en",       64'(en), 64'(0));
      chk("reset_busy",     64'(busy), 64'(0));
      chk("reset_done",     64'(done), 64'(0));
      chk("reset_a_left",   64'(a_left), 64'(0));
      chk("reset_b_top",    64'(b_top), 64'(0));

      run_tile(1, 0, 1, 0, 0);     // single beat, lanes 1..4
      run_tile(4, 2, 0, 0, 0);     // two-cycle stall after beat 2
      run_tile(0, 0, 0, 0, 0);     // empty tile
      run_tile(7, 0, 0, 5, 0);     // second start during feed
      run_tile(3, 0, 0, 0, 8);     // reset lands in drain
      run_tile(3, 0, 0, 0, 0);     // fresh tile after reset
      run_tile(8, 0, 2, 0, 0);     // full tile with extreme lane values
      run_tile(8, 1, 2, 0, 0);
      for (int t = 0; t < 20; t++)
         run_tile($urandom_range(0, 12), 1, 0, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
